serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor for the EDSAC arithmetic path: computes difference = a − b on LSB-first serial streams, one bit per enabled clock.
- Pairs with the serial adder. It uses a delayed borrow in place of the delayed carry, and explicit word framing so the borrow never leaks across word boundaries.
- Supports short (17-bit) and long (35-bit) words, chosen per word.
- At the end of each word it reports the result sign and overflow to the accumulator/sequencing control.

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per bit_en strobe.
// Word framing clears the borrow at each LSB and reports sign/overflow after the MSB.
module serial_subtractor #(
    parameter int SHORT_BITS = 17,
    parameter int LONG_BITS  = 35
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_en,
    input  logic word_start,
    input  logic long_mode,
    input  logic a,
    input  logic b,
    output logic diff,
    output logic diff_valid,
    output logic result_neg,
    output logic result_ovf,
    output logic flags_valid,
    output logic abort
);
    localparam int CW = $clog2(LONG_BITS);
    localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_BITS - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_BITS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          borrow;
    logic          len_sel, len_sel_nxt;
    logic          accept, msb, restart;
    logic          bin, d, bout, ovf;
    logic [CW-1:0] last_idx;

    // Borrow-in is forced to zero on any framed LSB so words never interact.
    assign bin      = word_start ? 1'b0 : borrow;
    assign d        = a ^ b ^ bin;
    assign bout     = (~a & b) | (~(a ^ b) & bin);
    assign ovf      = (a ^ b) & (d ^ a);
    assign last_idx = len_sel ? LONG_LAST : SHORT_LAST;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        len_sel_nxt = len_sel;
        accept      = 1'b0;
        msb         = 1'b0;
        restart     = 1'b0;
        case (state)
            IDLE: begin
                if (bit_en && word_start) begin
                    accept      = 1'b1;
                    cnt_nxt     = CW'(1);
                    len_sel_nxt = long_mode;
                    state_nxt   = RUN;
                end
            end
            RUN: begin
                if (bit_en) begin
                    accept = 1'b1;
                    if (word_start) begin
                        restart     = 1'b1;
                        cnt_nxt     = CW'(1);
                        len_sel_nxt = long_mode;
                    end else if (cnt == last_idx) begin
                        msb       = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            borrow  <= 1'b0;
            len_sel <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            len_sel <= len_sel_nxt;
            if (accept)
                borrow <= bout;
        end
    end

    // Output registers: everything appears one clock after the enabled bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff        <= 1'b0;
            diff_valid  <= 1'b0;
            result_neg  <= 1'b0;
            result_ovf  <= 1'b0;
            flags_valid <= 1'b0;
            abort       <= 1'b0;
        end else begin
            diff_valid  <= accept;
            flags_valid <= msb;
            abort       <= restart;
            if (accept)
                diff <= d;
            if (msb) begin
                result_neg <= d;
                result_ovf <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected bits/flags/aborts,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n, bit_en, word_start, long_mode, a, b;
    logic diff, diff_valid, result_neg, result_ovf, flags_valid, abort;

    int checks = 0;
    int errors = 0;

    bit       diff_q[$];
    bit [1:0] flag_q[$];
    bit       abort_q[$];

    serial_subtractor dut (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .word_start(word_start),
        .long_mode(long_mode), .a(a), .b(b), .diff(diff), .diff_valid(diff_valid),
        .result_neg(result_neg), .result_ovf(result_ovf), .flags_valid(flags_valid),
        .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step(input logic en, input logic ws, input logic lm, input logic ai, input logic bi);
        bit_en = en; word_start = ws; long_mode = lm; a = ai; b = bi;
        @(posedge clk);
        #1;
    endtask

    // Sends n bits of a word; flags are expected only when the full width is sent.
    task automatic send_word(input logic [34:0] aw, input logic [34:0] bw, input logic [34:0] exp_d,
                             input int n, input bit lng, input bit gaps, input bit toggle,
                             input bit neg, input bit ovf);
        int width;
        width = lng ? 35 : 17;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0)
                repeat ($urandom_range(0, 2))
                    step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            diff_q.push_back(exp_d[i]);
            if (i == n - 1 && n == width)
                flag_q.push_back({neg, ovf});
            step(1'b1, i == 0, (toggle && i > 0) ? ~lng : lng, aw[i], bw[i]);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_diff"}, diff, 0);
        chk({tag, "_diff_valid"}, diff_valid, 0);
        chk({tag, "_result_neg"}, result_neg, 0);
        chk({tag, "_result_ovf"}, result_ovf, 0);
        chk({tag, "_flags_valid"}, flags_valid, 0);
        chk({tag, "_abort"}, abort, 0);
    endtask

    // Monitor
    initial begin
        bit       e;
        bit [1:0] f;
        forever begin
            @(negedge clk);
            if (diff_valid) begin
                if (diff_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL diff_unexpected: got diff_valid=1 expected no output at %0t", $time);
                end else begin
                    e = diff_q.pop_front();
                    chk("diff_bit", diff, e);
                end
            end
            if (flags_valid) begin
                if (flag_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL flags_unexpected: got flags_valid=1 expected none at %0t", $time);
                end else begin
                    f = flag_q.pop_front();
                    chk("result_neg", result_neg, f[1]);
                    chk("result_ovf", result_ovf, f[0]);
                end
            end
            if (abort) begin
                if (abort_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL abort_unexpected: got abort=1 expected none at %0t", $time);
                end else begin
                    e = abort_q.pop_front();
                    chk("abort", abort, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; bit_en = 0; word_start = 0; long_mode = 0; a = 0; b = 0;
        #2;
        check_reset_values("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back short words; 7-7 also toggles long_mode mid-word.
        send_word(35'h00005, 35'h00003, 35'h00002, 17, 0, 0, 0, 0, 0);
        send_word(35'h00003, 35'h00005, 35'h1FFFE, 17, 0, 0, 0, 1, 0);
        send_word(35'h00007, 35'h00007, 35'h00000, 17, 0, 0, 1, 0, 0);
        // Overflow cases
        send_word(35'h0FFFF, 35'h10000, 35'h1FFFF, 17, 0, 0, 0, 1, 1);
        send_word(35'h10000, 35'h00001, 35'h0FFFF, 17, 0, 0, 0, 0, 1);
        // Long word with long_mode toggling after the LSB
        send_word(35'h400000000, 35'h000000001, 35'h3FFFFFFFF, 35, 1, 0, 1, 0, 1);
        // Unframed bits in IDLE are ignored
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // Random bit_en gaps
        send_word(35'h00005, 35'h00003, 35'h00002, 17, 0, 1, 0, 0, 0);
        // Mid-word restart at bit 8
        send_word(35'h00005, 35'h00003, 35'h00002, 8, 0, 0, 0, 0, 0);
        abort_q.push_back(1'b1);
        send_word(35'h00003, 35'h00005, 35'h1FFFE, 17, 0, 0, 0, 1, 0);

        // Set neg/ovf to 1 so the reset clearing is observable
        send_word(35'h0FFFF, 35'h10000, 35'h1FFFF, 17, 0, 0, 0, 1, 1);
        send_word(35'h00005, 35'h00003, 35'h00002, 10, 0, 0, 0, 0, 0);
        bit_en = 1'b1; word_start = 1'b0; a = 1'b1; b = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        bit_en = 1'b0;
        @(posedge clk); #1;
        check_reset_values("held_rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        send_word(35'h00009, 35'h00004, 35'h00005, 17, 0, 0, 0, 0, 0);

        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("diff_q_drained", diff_q.size(), 0);
        chk("flag_q_drained", flag_q.size(), 0);
        chk("abort_q_drained", abort_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
